// File: rtl/mcht_rsp_pkg.sv
// mcht_rsp_pkg: shared request-frame layout, opcodes and responder FSM states.
package mcht_rsp_pkg;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 14;
  localparam int ADDR_MSB = 13;
  localparam int ADDR_LSB = 11;
  localparam int SEQ_MSB = 10;
  localparam int SEQ_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [OP_MSB-OP_LSB:0] {
    OP_NOP  = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_ECHO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SEND,
    ST_WAIT
  } rsp_st_e;

  typedef struct packed {
    op_e                        op;
    logic [ADDR_MSB-ADDR_LSB:0] addr;
    logic [SEQ_MSB-SEQ_LSB:0]   seq;
    logic [DATA_MSB-DATA_LSB:0] data;
  } req_t;
endpackage

// File: rtl/mcht_rsp_fifo.sv
// mcht_rsp_fifo: show-ahead synchronous FIFO; caller guarantees no push when full without a pop.
module mcht_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= push_i ? wp_q + 1'b1 : wp_q;
      rp_q <= pop_i ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rp_q];
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/mcht_reg_rsp.sv
// mcht_reg_rsp: Manchester-link far-end responder with an 8x8 register file.
// Define MCHT_RSP_TIMEOUT_EN to build the TX_DNE watchdog (pTO_CYC cycles in WAIT).
module mcht_reg_rsp
  import mcht_rsp_pkg::*;
#(
  parameter int pFIFO_DEPTH = 2,
  parameter int pTO_CYC = 4096
) (
  input  logic        CLK_25M,
  input  logic        RST,
  input  logic [15:0] RX_MSG,
  input  logic        RX_VLD,
  output logic [15:0] TX_MSG,
  output logic        TX_VLD,
  input  logic        TX_DNE,
  output logic [63:0] REG_Q,
  output logic [7:0]  DROP_CNT,
  output logic [7:0]  TO_CNT
);
  rsp_st_e state_q, state_d;
  req_t req_q, req_d;
  logic [7:0][7:0] regs_q, regs_d;
  logic [15:0] tx_msg_q, tx_msg_d, fifo_rd;
  logic [7:0] drop_q, drop_d;
  logic tx_vld_q, tx_vld_d, full, empty, push, pop, nop, to_hit;

  assign pop = state_q == ST_IDLE && !empty;
  assign push = RX_VLD && (!full || pop);
  assign nop = req_q.op == OP_NOP;

  mcht_rsp_fifo #(.DEPTH(pFIFO_DEPTH), .W(16)) u_fifo (
    .clk    (CLK_25M),
    .rst    (RST),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(RX_MSG),
    .rdata_o(fifo_rd),
    .full_o (full),
    .empty_o(empty)
  );

`ifdef MCHT_RSP_TIMEOUT_EN
  localparam int TW = $clog2(pTO_CYC);
  logic [TW-1:0] wcnt_q;
  logic [7:0] to_q;
  // TX_DNE on the expiry cycle wins, so it is not a timeout
  assign to_hit = state_q == ST_WAIT && !TX_DNE && wcnt_q == TW'(pTO_CYC - 1);
  always_ff @(posedge CLK_25M or posedge RST) begin
    if (RST) begin
      wcnt_q <= '0;
      to_q <= '0;
    end else begin
      wcnt_q <= state_q == ST_WAIT ? wcnt_q + 1'b1 : '0;
      to_q <= (to_hit && to_q != 8'hFF) ? to_q + 8'd1 : to_q;
    end
  end
  assign TO_CNT = to_q;
`else
  assign to_hit = 1'b0;
  assign TO_CNT = '0;
`endif

  always_ff @(posedge CLK_25M or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == ST_IDLE ? (empty ? ST_IDLE : ST_EXEC) :
              state_q == ST_EXEC ? (nop ? ST_IDLE : ST_SEND) :
              state_q == ST_SEND ? ST_WAIT :
              (TX_DNE || to_hit) ? ST_IDLE : ST_WAIT;
  end

  always_comb begin
    req_d = pop ? req_t'(fifo_rd) : req_q;
    regs_d = regs_q;
    if (state_q == ST_EXEC && req_q.op == OP_WR) regs_d[req_q.addr] = req_q.data;
    tx_msg_d = (state_q == ST_EXEC && !nop) ?
               {req_q.op, req_q.addr, req_q.seq, req_q.op == OP_RD ? regs_q[req_q.addr] : req_q.data} :
               tx_msg_q;
    tx_vld_d = state_q == ST_EXEC && !nop;
    drop_d = (RX_VLD && !push && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge CLK_25M or posedge RST) begin
    if (RST) begin
      req_q <= '0;
      regs_q <= '0;
      tx_msg_q <= '0;
      tx_vld_q <= 1'b0;
      drop_q <= '0;
    end else begin
      req_q <= req_d;
      regs_q <= regs_d;
      tx_msg_q <= tx_msg_d;
      tx_vld_q <= tx_vld_d;
      drop_q <= drop_d;
    end
  end

  assign TX_MSG = tx_msg_q;
  assign TX_VLD = tx_vld_q;
  assign REG_Q = regs_q;
  assign DROP_CNT = drop_q;
endmodule

// File: tb/tb_mcht_reg_rsp.sv
// tb_mcht_reg_rsp: scoreboard bench for mcht_reg_rsp; timeout checks run when MCHT_RSP_TIMEOUT_EN is defined.
module tb_mcht_reg_rsp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rx_msg = '0;
  logic        rx_vld = 1'b0;
  logic [15:0] tx_msg;
  logic        tx_vld;
  logic        tx_dne = 1'b0;
  logic [63:0] reg_q;
  logic [7:0]  drop_cnt, to_cnt;

  int tests = 0;
  int fails = 0;
  int seen = 0;
  int exp_n = 0;
  logic [15:0] sb [$];

  mcht_reg_rsp #(.pFIFO_DEPTH(2), .pTO_CYC(16)) dut (
    .CLK_25M (clk),
    .RST     (rst),
    .RX_MSG  (rx_msg),
    .RX_VLD  (rx_vld),
    .TX_MSG  (tx_msg),
    .TX_VLD  (tx_vld),
    .TX_DNE  (tx_dne),
    .REG_Q   (reg_q),
    .DROP_CNT(drop_cnt),
    .TO_CNT  (to_cnt)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tx_vld) begin
      seen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_reply: got 0x%04h expected none", tx_msg);
      end else chk("reply", {48'h0, tx_msg}, {48'h0, sb.pop_front()});
    end
  end

  // Drive one request frame; call just after a rising edge.
  task automatic issue(input logic [15:0] m, input bit reply, input logic [15:0] exp);
    if (reply) begin
      sb.push_back(exp);
      exp_n++;
    end
    rx_msg = m;
    rx_vld = 1'b1;
    @(posedge clk);
    #1 rx_vld = 1'b0;
  endtask

  // Wait until all expected replies are seen, ending on a rising edge.
  task automatic wait_seen();
    int i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (seen < exp_n && i < 60);
    if (seen < exp_n) chk("reply_timeout", 64'(seen), 64'(exp_n));
  endtask

  task automatic pulse_done();
    #1 tx_dne = 1'b1;
    @(posedge clk);
    #1 tx_dne = 1'b0;
  endtask

  initial begin
    int lat;
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_msg", {48'h0, tx_msg}, 64'h0);
    chk("rst_tx_vld", {63'h0, tx_vld}, 64'h0);
    chk("rst_reg_q", reg_q, 64'h0);
    chk("rst_drop", {56'h0, drop_cnt}, 64'h0);
    chk("rst_to", {56'h0, to_cnt}, 64'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // WR 0x5A to addr 3, latency measured in falling edges after the sampling edge
    issue(16'h5D5A, 1'b1, 16'h5D5A);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (tx_vld) lat = i;
    end
    chk("wr_latency", 64'(lat), 64'd3);
    chk("wr_reg_q", reg_q, 64'h0000_0000_5A00_0000);
    wait_seen();
    pulse_done();

    issue(16'h9800, 1'b1, 16'h985A);
    wait_seen();
    pulse_done();
    issue(16'hC7A5, 1'b1, 16'hC7A5);
    wait_seen();
    pulse_done();
    chk("echo_reg_q", reg_q, 64'h0000_0000_5A00_0000);

    // NOP produces nothing; a following ECHO proves the FSM returned to IDLE
    issue(16'h0000, 1'b0, 16'h0);
    lat = seen;
    repeat (10) @(negedge clk);
    chk("nop_no_reply", 64'(seen), 64'(lat));
    @(posedge clk);
    #1 issue(16'hC0E1, 1'b1, 16'hC0E1);
    wait_seen();
    pulse_done();

    // four back-to-back frames: one executing, two buffered, one dropped
    issue(16'hC111, 1'b1, 16'hC111);
    issue(16'hC222, 1'b1, 16'hC222);
    issue(16'hC333, 1'b1, 16'hC333);
    issue(16'hC444, 1'b0, 16'h0);
    chk("burst_drop", {56'h0, drop_cnt}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      exp_n = exp_n - 2 + k;
      wait_seen();
      exp_n = exp_n + 2 - k;
      pulse_done();
    end
    chk("burst_drain", 64'(seen), 64'(exp_n));

    // RD after WR to the same address in FIFO order
    issue(16'h6A77, 1'b1, 16'h6A77);
    issue(16'hAB00, 1'b1, 16'hAB77);
    exp_n--;
    wait_seen();
    exp_n++;
    pulse_done();
    wait_seen();
    pulse_done();
    chk("rdwr_reg_q", reg_q, 64'h0000_7700_5A00_0000);

    // reset while waiting for TX_DNE with a frame still buffered
    issue(16'h4933, 1'b1, 16'h4933);
    issue(16'hC2AA, 1'b0, 16'h0);
    wait_seen();
    chk("pre_rst_reg_q", reg_q, 64'h0000_7700_5A00_3300);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_tx_vld", {63'h0, tx_vld}, 64'h0);
    chk("mid_rst_reg_q", reg_q, 64'h0);
    chk("mid_rst_drop", {56'h0, drop_cnt}, 64'h0);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_silent", 64'(seen), 64'(exp_n));

`ifdef MCHT_RSP_TIMEOUT_EN
    @(posedge clk);
    #1 issue(16'hC3B4, 1'b1, 16'hC3B4);
    wait_seen();
    repeat (15) @(posedge clk);
    #1 chk("to_not_yet", {56'h0, to_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("to_cnt", {56'h0, to_cnt}, 64'd1);
    issue(16'hC5C6, 1'b1, 16'hC5C6);
    wait_seen();
    pulse_done();
    chk("to_next_served", 64'(seen), 64'(exp_n));
`else
    @(posedge clk);
    #1 issue(16'hC3B4, 1'b1, 16'hC3B4);
    wait_seen();
    repeat (40) @(posedge clk);
    #1 chk("to_cnt_off", {56'h0, to_cnt}, 64'd0);
    pulse_done();
`endif

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
